// File: rtl/dmux_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream_if
// Brief    : Producer-side and consumer-side stream bundle for dmux_stream.
// Revision : 1.0
// ============================================================================
interface dmux_stream_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_last;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/dmux_stream.sv
`default_nettype none
// ============================================================================
// Module   : dmux_stream
// Brief    : Registered 1-to-CHANNELS stream demux with packet route lock.
//            Optional per-channel packet counters: DMUX_STREAM_COUNT_EN.
// Revision : 1.0
// ============================================================================
module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  dmux_stream_if.slave      bus,
`ifdef DMUX_STREAM_COUNT_EN
  input  wire logic [$clog2(CHANNELS)-1:0] cnt_sel,
  output logic      [15:0]                 cnt_val,
`endif
  output logic              busy
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic [SEL_W-1:0] r_route;
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [SEL_W-1:0] r_dest;

  logic             w_dest_ready;
  logic             w_ready;
  logic             w_accept;
  logic             w_drain;
  logic [SEL_W-1:0] w_dest_next;

  assign w_dest_ready = bus.out_ready[r_dest];
  assign w_ready      = !r_full || w_dest_ready;
  assign w_accept     = bus.in_valid && w_ready;
  assign w_drain      = r_full && w_dest_ready;
  assign w_dest_next  = (r_state == S_IDLE) ? bus.in_sel : r_route;

  assign bus.in_ready = w_ready;
  assign busy         = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_route <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.in_last) begin
            r_state <= S_LOCKED;
            r_busy  <= 1'b1;
            r_route <= bus.in_sel;
          end
        end
        S_LOCKED: begin
          if (bus.in_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Inputs are only captured on accept so idle-cycle X never reaches the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_dest <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= bus.in_data;
      r_last <= bus.in_last;
      r_dest <= w_dest_next;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic w_hit;
      assign w_hit                         = r_full && (r_dest == SEL_W'(i));
      assign bus.out_valid[i]              = w_hit;
      assign bus.out_last[i]               = w_hit && r_last;
      assign bus.out_data[i*WIDTH +: WIDTH] = w_hit ? r_data : '0;
    end
  endgenerate

`ifdef DMUX_STREAM_COUNT_EN
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [15:0] r_cnt [CHANNELS];

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[i] <= '0;
        end else if (w_drain && r_last && (r_dest == SEL_W'(i)) && (r_cnt[i] != c_CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  endgenerate

  assign cnt_val = r_cnt[cnt_sel];
`endif

endmodule
`default_nettype wire

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised, registered stream demultiplexer; successor to the fixed 8-way combinational demux.
- Routes a WIDTH-bit valid/ready stream to one of CHANNELS outputs.
- Latches the route at the start of each packet and holds it until the packet's last beat.
- Sits between a single producer (e.g. a memory/IO decoder front end) and CHANNELS independent consumers; one pipeline register stage with full backpressure.

Parameters:
- WIDTH, 16, data bits per beat.
- CHANNELS, 8, number of output channels; power of two, 2..64.
- SEL_W, $clog2(CHANNELS), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SEL_W  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_last  output  CHANNELS  per-channel last flag.
- out_valid  output  CHANNELS  per-channel valid; at most one bit set.
- out_ready  input  CHANNELS  per-channel consumer ready.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_last=0, out_data=0, busy=0, route register=0, state=IDLE, holding register empty. in_ready=1 after reset.
- Holding register: one entry (data, last, dest, full flag).
- in_ready = !full || out_ready[dest]; purely combinational, no combinational path from in_valid.
- Accept: in_valid && in_ready. The beat is written into the holding register on the next clock edge, giving 1-cycle latency from accept to out_valid.
- Drain: full && out_ready[dest] clears full, unless an accept occurs in the same cycle, in which case the register is reloaded (full throughput, 1 beat/cycle).
- Outputs:
  - out_valid[i] = full && dest==i.
  - out_last[i] = full && dest==i && last.
  - out_data slice i = stored data when dest==i, else all zeros; non-selected channels are always 0, as in the classic demux.
- Route FSM:
  - IDLE: on accept, dest_next=in_sel. If !in_last, go to LOCKED with route=in_sel; a single-beat packet stays in IDLE.
  - LOCKED: in_sel is ignored; dest_next=route. On an accept with in_last, return to IDLE.
  - busy = (state==LOCKED).
- out_ready on non-selected channels is ignored.
- A stalled selected channel blocks all traffic; head-of-line blocking is intended.
- in_valid low mid-packet: stay in LOCKED indefinitely.
- Reset mid-packet: the packet is discarded and the FSM returns to IDLE; no partial beat appears on any output.
- in_data/in_sel/in_last are don't-care when in_valid=0; X on them must not propagate.

Optional Feature:
- Macro: DMUX_STREAM_COUNT_EN.
- When defined:
  - Adds input port cnt_sel (SEL_W) and output port cnt_val (16).
  - Adds a per-channel 16-bit packet counter, incremented when a beat with last is drained on that channel; saturates at 16'hFFFF.
  - cnt_val = counter[cnt_sel], combinational read.
  - Counters reset to 0 on rst_n.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, busy=0; after release in_ready=1.
- Single beat: in_sel=5, in_data=16'hA5A5, in_last=1, out_ready=all 1 -> one cycle later out_valid=8'b0010_0000, slice 5=16'hA5A5, out_last[5]=1, all other slices 0, busy stays 0.
- Packet lock: 4-beat packet with first in_sel=2, then in_sel changed to 7 on beats 2-4 -> all 4 beats appear on channel 2; busy high from after beat 1 until beat 4 accepted.
- Backpressure: out_ready[3]=0 for 3 cycles during a packet to ch3 -> in_ready=0 after the register fills, data held stable; release -> beats delivered in order, none lost or duplicated; out_ready on other channels has no effect.
- Throughput: back-to-back single-beat packets to ch0,1,2,...,7 with out_ready=all 1 -> one beat per cycle, in_ready continuously 1.
- Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet to ch6 -> immediate out_valid=0; next packet with in_sel=1 routes to ch1. With DMUX_STREAM_COUNT_EN: 3 packets to ch4 -> cnt_sel=4 gives cnt_val=3.
